// File: rtl/logic_axi4_stream_packetizer_if.sv
// AXI4-Stream bundle shared by the packetizer's input and output sides.
// master/tx drive the payload and tvalid; slave/rx drive tready.
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic                     tlast;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TID_WIDTH-1:0]     tid;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, tkeep, tstrb, tlast, tdest, tid, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tstrb, tlast, tdest, tid, tuser, tvalid, output tready);
  modport tx     (output tdata, tkeep, tstrb, tlast, tdest, tid, tuser, tvalid, input tready);
  modport rx     (input tdata, tkeep, tstrb, tlast, tdest, tid, tuser, tvalid, output tready);
endinterface

// File: rtl/logic_axi4_stream_packetizer.sv
// Frames an AXI4-Stream into packets (length limit, idle timeout, tdest/tid change, rx.tlast).
// Optional flush input enabled by defining LOGIC_AXI4_STREAM_PACKETIZER_FLUSH_EN.
module logic_axi4_stream_packetizer #(
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TLAST   = 1,
  parameter int USE_TKEEP   = 1,
  parameter int USE_TSTRB   = 1,
  parameter int MAX_LENGTH  = 256,
  parameter int TIMEOUT     = 1024
) (
  input  logic aclk,
  input  logic areset_n,
`ifdef LOGIC_AXI4_STREAM_PACKETIZER_FLUSH_EN
  input  logic flush,
`endif
  logic_axi4_stream_if.rx rx,
  logic_axi4_stream_if.tx tx
);
  localparam int DW = TDATA_BYTES * 8;
  localparam int IW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(MAX_LENGTH - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic                   run_reg;
  logic                   h_valid_reg, h_close_reg;
  logic [DW-1:0]          h_data_reg, o_data_reg;
  logic [TDATA_BYTES-1:0] h_keep_reg, h_strb_reg, o_keep_reg, o_strb_reg;
  logic [TDEST_WIDTH-1:0] h_dest_reg, o_dest_reg;
  logic [TID_WIDTH-1:0]   h_id_reg, o_id_reg;
  logic [TUSER_WIDTH-1:0] h_user_reg, o_user_reg;
  logic                   o_valid_reg, o_last_reg;
  logic [IW-1:0]          index_reg;
  logic [TW-1:0]          timer_reg;

  logic                   o_free, rx_ready, rx_accept, id_change;
  logic                   timeout_hit, flush_hit, close_evt, move, move_last, h_close_in;
  logic [IW-1:0]          index_in;
  logic [TDATA_BYTES-1:0] keep_in, strb_in;

  // Disabled side-band lanes are forced to all-ones so downstream sees full beats.
  genvar gi;
  generate
    for (gi = 0; gi < TDATA_BYTES; gi++) begin : g_lane
      assign keep_in[gi] = (USE_TKEEP != 0) ? rx.tkeep[gi] : 1'b1;
      assign strb_in[gi] = (USE_TSTRB != 0) ? rx.tstrb[gi] : 1'b1;
    end
  endgenerate

  assign o_free    = !o_valid_reg || tx.tready;
  assign rx_ready  = run_reg && (!h_valid_reg || o_free);
  assign rx.tready = rx_ready;
  assign rx_accept = rx.tvalid && rx_ready;
  assign id_change = rx_accept && h_valid_reg &&
                     ((rx.tdest != h_dest_reg) || (rx.tid != h_id_reg));

  // The timer saturates at its last value, so a timeout blocked by O stays pending.
  assign timeout_hit = (TIMEOUT != 0) && h_valid_reg && (timer_reg == TMR_LAST);

`ifdef LOGIC_AXI4_STREAM_PACKETIZER_FLUSH_EN
  logic flush_pend_reg;
  assign flush_hit = h_valid_reg && (flush || flush_pend_reg);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      flush_pend_reg <= 1'b0;
    end else if (move) begin
      flush_pend_reg <= 1'b0;
    end else if (flush && h_valid_reg) begin
      flush_pend_reg <= 1'b1;
    end
  end
`else
  assign flush_hit = 1'b0;
`endif

  assign close_evt = timeout_hit || flush_hit;
  assign move      = h_valid_reg && o_free && (h_close_reg || rx_accept || close_evt);
  assign move_last = h_close_reg || close_evt || id_change;

  // Position of the incoming beat: follows the held beat unless that beat ends its packet.
  assign index_in   = (h_valid_reg && !move_last) ? index_reg + 1'b1 : '0;
  assign h_close_in = (index_in == IDX_LAST) || ((USE_TLAST != 0) && rx.tlast);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      run_reg     <= 1'b0;
      h_valid_reg <= 1'b0;
      h_close_reg <= 1'b0;
      o_valid_reg <= 1'b0;
      o_last_reg  <= 1'b0;
      index_reg   <= '0;
      timer_reg   <= '0;
    end else begin
      run_reg <= 1'b1;

      if (rx_accept) begin
        h_valid_reg <= 1'b1;
        h_close_reg <= h_close_in;
        index_reg   <= index_in;
      end else if (move) begin
        h_valid_reg <= 1'b0;
        h_close_reg <= 1'b0;
        index_reg   <= '0;
      end

      if (move) begin
        o_valid_reg <= 1'b1;
        o_last_reg  <= move_last;
      end else if (tx.tready) begin
        o_valid_reg <= 1'b0;
        o_last_reg  <= 1'b0;
      end

      if (rx_accept || move || !h_valid_reg) begin
        timer_reg <= '0;
      end else if (!timeout_hit) begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rx_accept) begin
      h_data_reg <= rx.tdata;
      h_keep_reg <= keep_in;
      h_strb_reg <= strb_in;
      h_dest_reg <= rx.tdest;
      h_id_reg   <= rx.tid;
      h_user_reg <= rx.tuser;
    end
    if (move) begin
      o_data_reg <= h_data_reg;
      o_keep_reg <= h_keep_reg;
      o_strb_reg <= h_strb_reg;
      o_dest_reg <= h_dest_reg;
      o_id_reg   <= h_id_reg;
      o_user_reg <= h_user_reg;
    end
  end

  assign tx.tvalid = o_valid_reg;
  assign tx.tlast  = o_last_reg;
  assign tx.tdata  = o_data_reg;
  assign tx.tkeep  = o_keep_reg;
  assign tx.tstrb  = o_strb_reg;
  assign tx.tdest  = o_dest_reg;
  assign tx.tid    = o_id_reg;
  assign tx.tuser  = o_user_reg;
endmodule

// File: tb/tb_logic_axi4_stream_packetizer.sv
// Directed bench for the packetizer: MAX_LENGTH=4, TIMEOUT=8, USE_TLAST=1.
module tb_logic_axi4_stream_packetizer;
  localparam int MAXL = 4;
  localparam int TMO  = 8;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
`ifdef LOGIC_AXI4_STREAM_PACKETIZER_FLUSH_EN
  logic flush = 1'b0;
`endif

  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) rx_bus ();
  logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) tx_bus ();

  logic_axi4_stream_packetizer #(
    .TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1),
    .USE_TLAST(1), .USE_TKEEP(1), .USE_TSTRB(1),
    .MAX_LENGTH(MAXL), .TIMEOUT(TMO)
  ) dut (
    .aclk(aclk),
    .areset_n(areset_n),
`ifdef LOGIC_AXI4_STREAM_PACKETIZER_FLUSH_EN
    .flush(flush),
`endif
    .rx(rx_bus),
    .tx(tx_bus)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] dest;
    int         cyc;
  } beat_t;
  beat_t mon_q[$];

  // Inputs change just after posedge, so the negedge view is what transfers next edge.
  always @(negedge aclk) begin
    if (tx_bus.tvalid === 1'b1 && tx_bus.tready === 1'b1) begin
      mon_q.push_back('{tx_bus.tdata, tx_bus.tlast, tx_bus.tdest, cyc});
      $display("[%0t] tx beat data=%02h last=%0b dest=%0d", $time, tx_bus.tdata, tx_bus.tlast, tx_bus.tdest);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; acc is the rx_accept cycle.
  task automatic send(input logic [7:0] d, input logic [1:0] dest, input logic last, output int acc);
    rx_bus.tvalid = 1'b1;
    rx_bus.tdata  = d;
    rx_bus.tdest  = dest;
    rx_bus.tlast  = last;
    rx_bus.tid    = 1'b0;
    rx_bus.tuser  = d[0];
    rx_bus.tkeep  = 1'b1;
    rx_bus.tstrb  = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (rx_bus.tready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("rx_accept_wait", rx_bus.tready, 1);
    @(posedge aclk);
    #1;
    rx_bus.tvalid = 1'b0;
    $display("[%0t] rx beat data=%02h dest=%0d last=%0b accepted_cycle=%0d", $time, d, dest, last, acc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] d, input logic [1:0] dest,
                         input logic last, output int c);
    beat_t b;
    c = 0;
    if (mon_q.size() == 0) begin
      chk({tag, "_present"}, mon_q.size(), 1);
    end else begin
      b = mon_q.pop_front();
      chk({tag, "_data"}, b.data, d);
      chk({tag, "_dest"}, b.dest, dest);
      chk({tag, "_last"}, b.last, last);
      c = b.cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int a, c;
    int acc0, acc3, acc22;

    rx_bus.tvalid = 1'b0;
    rx_bus.tdata  = '0;
    rx_bus.tdest  = '0;
    rx_bus.tlast  = 1'b0;
    rx_bus.tid    = '0;
    rx_bus.tuser  = '0;
    rx_bus.tkeep  = '1;
    rx_bus.tstrb  = '1;
    tx_bus.tready = 1'b1;
    acc0 = 0; acc3 = 0; acc22 = 0;

    // Reset state
    repeat (3) @(posedge aclk);
    #2;
    chk("rst_tvalid", tx_bus.tvalid, 0);
    chk("rst_tlast", tx_bus.tlast, 0);
    chk("rst_rx_tready", rx_bus.tready, 0);
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    @(posedge aclk);
    #2;
    chk("rx_tready_after_release", rx_bus.tready, 1);
    idle(2);

    // Continuous 0..11: packets of 4, tlast on 3, 7, 11
    for (int i = 0; i < 12; i++) begin
      send(8'(i), 2'd0, 1'b0, a);
      if (i == 0) acc0 = a;
      if (i == 3) acc3 = a;
    end
    idle(15);
    for (int i = 0; i < 12; i++) begin
      pop_chk("len", 8'(i), 2'd0, (i % MAXL) == (MAXL - 1), c);
      if (i == 0) chk("len_latency_beat0", c - acc0, 2);
      if (i == 3) chk("len_latency_beat3", c - acc3, 2);
    end

    // Three beats then idle: the held beat closes on timeout.
    // Timer runs 0..7 over 8 idle cycles, then one cycle into the output register.
    send(8'h20, 2'd0, 1'b0, a);
    send(8'h21, 2'd0, 1'b0, a);
    send(8'h22, 2'd0, 1'b0, acc22);
    idle(20);
    pop_chk("tmo0", 8'h20, 2'd0, 1'b0, c);
    pop_chk("tmo1", 8'h21, 2'd0, 1'b0, c);
    pop_chk("tmo2", 8'h22, 2'd0, 1'b1, c);
    chk("tmo_latency", c - acc22, TMO + 1);
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 2'd0, 1'b0, a);
    idle(15);
    for (int i = 0; i < 4; i++) pop_chk("tmo_next", 8'h30 + 8'(i), 2'd0, i == 3, c);

    // tdest 1,1,2,2: close on the change, last beat closed by timeout
    send(8'h40, 2'd1, 1'b0, a);
    send(8'h41, 2'd1, 1'b0, a);
    send(8'h42, 2'd2, 1'b0, a);
    send(8'h43, 2'd2, 1'b0, a);
    idle(20);
    pop_chk("dest0", 8'h40, 2'd1, 1'b0, c);
    pop_chk("dest1", 8'h41, 2'd1, 1'b1, c);
    pop_chk("dest2", 8'h42, 2'd2, 1'b0, c);
    pop_chk("dest3", 8'h43, 2'd2, 1'b1, c);

    // tx stalled 20 cycles: two beats stored, held beat times out while blocked
    tx_bus.tready = 1'b0;
    fork
      begin
        int b;
        for (int i = 0; i < 6; i++) send(8'h50 + 8'(i), 2'd0, 1'b0, b);
      end
      begin
        repeat (6) @(posedge aclk);
        #2;
        chk("bp_rx_tready", rx_bus.tready, 0);
        chk("bp_tvalid", tx_bus.tvalid, 1);
        chk("bp_tdata_hold", tx_bus.tdata, 8'h50);
        repeat (14) @(posedge aclk);
        #2;
        chk("bp_tdata_hold_late", tx_bus.tdata, 8'h50);
        chk("bp_rx_tready_late", rx_bus.tready, 0);
        tx_bus.tready = 1'b1;
      end
    join
    idle(20);
    pop_chk("bp0", 8'h50, 2'd0, 1'b0, c);
    pop_chk("bp1", 8'h51, 2'd0, 1'b1, c);
    pop_chk("bp2", 8'h52, 2'd0, 1'b0, c);
    pop_chk("bp3", 8'h53, 2'd0, 1'b0, c);
    pop_chk("bp4", 8'h54, 2'd0, 1'b0, c);
    pop_chk("bp5", 8'h55, 2'd0, 1'b1, c);

    // rx.tlast on 0x62 closes early; the index restarts so 0x66 is the 4th of the next packet
    for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 2'd0, i == 2, a);
    idle(20);
    for (int i = 0; i < 8; i++) pop_chk("tl", 8'h60 + 8'(i), 2'd0, (i == 2) || (i == 6) || (i == 7), c);

    // Reset with H and O both full: nothing of the partial packet comes out
    tx_bus.tready = 1'b0;
    send(8'h70, 2'd0, 1'b0, a);
    send(8'h71, 2'd0, 1'b0, a);
    #2;
    chk("rstmid_full_tvalid", tx_bus.tvalid, 1);
    #1;
    areset_n = 1'b0;
    #1;
    chk("rstmid_tvalid_async", tx_bus.tvalid, 0);
    chk("rstmid_tlast", tx_bus.tlast, 0);
    chk("rstmid_rx_tready", rx_bus.tready, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset_n = 1'b1;
    tx_bus.tready = 1'b1;
    idle(12);
    chk("rstmid_no_partial", mon_q.size(), 0);
    for (int i = 0; i < 4; i++) send(8'h80 + 8'(i), 2'd0, 1'b0, a);
    idle(15);
    for (int i = 0; i < 4; i++) pop_chk("rstmid_new", 8'h80 + 8'(i), 2'd0, i == 3, c);
    chk("final_queue_empty", mon_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
